// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for the Harris corner detector: pixel intake, clock-enable
// gating, config latching, pipeline flush and (x,y)/corner tagging of results.
module harris_frame_ctrl #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          LAT        = 1283,
    parameter logic [17:0] DEF_THRESH = 18'd1000,
    parameter logic [3:0]  DEF_SCALE  = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [23:0] in_rgb,
    output logic        in_ready,
    input  logic        cfg_wr,
    input  logic [17:0] cfg_threshold,
    input  logic [3:0]  cfg_scale,
    input  logic [17:0] corner_thresh,
    output logic        det_clk_en,
    output logic [23:0] det_rgb,
    output logic [17:0] det_threshold,
    output logic [3:0]  det_scale,
    input  logic [17:0] harris_feature,
    output logic        feat_valid,
    output logic [9:0]  feat_x,
    output logic [8:0]  feat_y,
    output logic        feat_corner,
    output logic [15:0] corner_count,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int CW   = $clog2(NPIX + LAT + 1);
    localparam int FW   = $clog2(LAT + 1);

    localparam logic [CW-1:0] NPIX_C  = CW'(NPIX);
    localparam logic [CW-1:0] LAT_C   = CW'(LAT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [FW-1:0] LAST_FL = FW'(LAT - 1);
    localparam logic [9:0]    XMAX    = 10'(H_ACTIVE - 1);
    localparam logic [8:0]    YMAX    = 9'(V_ACTIVE - 1);
    localparam logic [9:0]    XBR     = 10'(H_ACTIVE - 2);
    localparam logic [8:0]    YBR     = 9'(V_ACTIVE - 2);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   en_cnt_q, en_cnt_d;
    logic [FW-1:0]   fl_cnt_q, fl_cnt_d;
    logic [CW-1:0]   e_cur;
    logic            sof_acc, restart, last_pulse, trigger;

    logic [17:0]     pend_thr_q, act_thr_q;
    logic [3:0]      pend_scl_q, act_scl_q;
    logic            pend_flag_q;

    logic [9:0]      ox_q, x1_q, fx_q;
    logic [8:0]      oy_q, y1_q, fy_q;
    logic            v1_q, last1_q, last2_q;
    logic            fv_q, fc_q, done_q, err_q;
    logic [15:0]     run_cnt_q, run_next, cc_q;
    logic            border1, is_corner;

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        en_cnt_d   = en_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        e_cur      = en_cnt_q;
        in_ready   = 1'b1;
        det_clk_en = 1'b0;
        det_rgb    = 24'd0;
        sof_acc    = 1'b0;
        restart    = 1'b0;
        last_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    sof_acc    = 1'b1;
                    det_clk_en = 1'b1;
                    det_rgb    = in_rgb;
                    e_cur      = '0;
                    in_cnt_d   = ONE_C;
                    en_cnt_d   = ONE_C;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    det_clk_en = 1'b1;
                    det_rgb    = in_rgb;
                    if (in_sof) begin
                        sof_acc  = 1'b1;
                        restart  = 1'b1;
                        e_cur    = '0;
                        in_cnt_d = ONE_C;
                        en_cnt_d = ONE_C;
                    end else begin
                        in_cnt_d = in_cnt_q + ONE_C;
                        en_cnt_d = en_cnt_q + ONE_C;
                        if (in_cnt_d == NPIX_C) begin
                            state_d  = FLUSH;
                            fl_cnt_d = '0;
                        end
                    end
                end
            end
            FLUSH: begin
                in_ready   = 1'b0;
                det_clk_en = 1'b1;
                en_cnt_d   = en_cnt_q + ONE_C;
                fl_cnt_d   = fl_cnt_q + FW'(1);
                if (fl_cnt_q == LAST_FL) begin
                    last_pulse = 1'b1;
                    state_d    = IDLE;
                    fl_cnt_d   = '0;
                    in_cnt_d   = '0;
                    en_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Pulse e carries the result for pixel e-LAT once the pipe has filled
    assign trigger = det_clk_en && (e_cur >= LAT_C);

    assign border1 = (x1_q < 10'd2) || (x1_q >= XBR) ||
                     (y1_q < 9'd2)  || (y1_q >= YBR);

    assign is_corner = $signed(harris_feature) > $signed(corner_thresh);

    assign run_next = run_cnt_q +
        16'((fv_q && fc_q && (run_cnt_q != 16'hFFFF)) ? 1 : 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q    <= '0;
            en_cnt_q    <= '0;
            fl_cnt_q    <= '0;
            pend_thr_q  <= DEF_THRESH;
            pend_scl_q  <= DEF_SCALE;
            pend_flag_q <= 1'b0;
            act_thr_q   <= DEF_THRESH;
            act_scl_q   <= DEF_SCALE;
            ox_q        <= '0;
            oy_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            fv_q        <= 1'b0;
            fx_q        <= '0;
            fy_q        <= '0;
            fc_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            run_cnt_q   <= '0;
            cc_q        <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
            en_cnt_q <= en_cnt_d;
            fl_cnt_q <= fl_cnt_d;

            if (cfg_wr) begin
                pend_thr_q  <= cfg_threshold;
                pend_scl_q  <= cfg_scale;
                pend_flag_q <= 1'b1;
            end
            if (sof_acc) begin
                pend_flag_q <= 1'b0;
                if (cfg_wr) begin
                    act_thr_q <= cfg_threshold;
                    act_scl_q <= cfg_scale;
                end else if (pend_flag_q) begin
                    act_thr_q <= pend_thr_q;
                    act_scl_q <= pend_scl_q;
                end
            end

            if (sof_acc) begin
                ox_q <= '0;
                oy_q <= '0;
            end else if (trigger) begin
                if (ox_q == XMAX) begin
                    ox_q <= '0;
                    oy_q <= (oy_q == YMAX) ? 9'd0 : oy_q + 9'd1;
                end else begin
                    ox_q <= ox_q + 10'd1;
                end
            end

            v1_q    <= trigger;
            last1_q <= last_pulse;
            if (trigger) begin
                x1_q <= ox_q;
                y1_q <= oy_q;
            end

            // A restart discards whatever the old frame still had in flight
            fv_q    <= v1_q && !restart;
            last2_q <= last1_q && !restart;
            if (v1_q) begin
                fx_q <= x1_q;
                fy_q <= y1_q;
                fc_q <= is_corner && !border1;
            end else begin
                fc_q <= 1'b0;
            end

            done_q <= last2_q;
            err_q  <= restart;

            run_cnt_q <= sof_acc ? 16'd0 : run_next;
            if (last2_q) cc_q <= run_next;
        end
    end

    assign det_threshold = act_thr_q;
    assign det_scale     = act_scl_q;
    assign feat_valid    = fv_q;
    assign feat_x        = fx_q;
    assign feat_y        = fy_q;
    assign feat_corner   = fc_q;
    assign corner_count  = cc_q;
    assign frame_done    = done_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Directed bench for harris_frame_ctrl on an 8x6 frame with LAT=19.
module tb_harris_frame_ctrl;

    localparam int H = 8;
    localparam int V = 6;
    localparam int L = 19;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] in_rgb = '0;
    logic        in_ready;
    logic        cfg_wr = 1'b0;
    logic [17:0] cfg_threshold = '0;
    logic [3:0]  cfg_scale = '0;
    logic [17:0] corner_thresh = 18'd50;
    logic        det_clk_en;
    logic [23:0] det_rgb;
    logic [17:0] det_threshold;
    logic [3:0]  det_scale;
    logic [17:0] harris_feature = 18'd100;
    logic        feat_valid;
    logic [9:0]  feat_x;
    logic [8:0]  feat_y;
    logic        feat_corner;
    logic [15:0] corner_count;
    logic        frame_done;
    logic        frame_err;

    harris_frame_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .LAT(L),
        .DEF_THRESH(18'd1000), .DEF_SCALE(4'd8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
        .in_ready(in_ready),
        .cfg_wr(cfg_wr), .cfg_threshold(cfg_threshold),
        .cfg_scale(cfg_scale), .corner_thresh(corner_thresh),
        .det_clk_en(det_clk_en), .det_rgb(det_rgb),
        .det_threshold(det_threshold), .det_scale(det_scale),
        .harris_feature(harris_feature),
        .feat_valid(feat_valid), .feat_x(feat_x), .feat_y(feat_y),
        .feat_corner(feat_corner), .corner_count(corner_count),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_en = 0, n_enrun = 0, n_noacc = 0, n_feat = 0;
    int n_done = 0, n_err = 0, n_rdy0 = 0, done_at = 0;
    int en_at [1024];
    int f_at  [1024];
    int fx    [1024];
    int fy    [1024];
    int fc    [1024];

    always @(negedge clk) begin
        if (!reset) begin
            if (det_clk_en) begin
                en_at[n_en % 1024] <= cyc;
                n_en <= n_en + 1;
                if (in_ready) n_enrun <= n_enrun + 1;
                if (in_ready && !in_valid) n_noacc <= n_noacc + 1;
            end
            if (feat_valid) begin
                f_at[n_feat % 1024] <= cyc;
                fx[n_feat % 1024]   <= int'(feat_x);
                fy[n_feat % 1024]   <= int'(feat_y);
                fc[n_feat % 1024]   <= int'(feat_corner);
                n_feat <= n_feat + 1;
            end
            if (frame_done) begin
                done_at <= cyc;
                n_done  <= n_done + 1;
            end
            if (frame_err) n_err <= n_err + 1;
            if (!in_ready) n_rdy0 <= n_rdy0 + 1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    int b_en, b_enrun, b_noacc, b_feat, b_done, b_err, b_rdy0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_en = n_en; b_enrun = n_enrun; b_noacc = n_noacc;
        b_feat = n_feat; b_done = n_done; b_err = n_err;
        b_rdy0 = n_rdy0;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int npix, input bit gaps,
                              input int cfg_at, input int ct,
                              input int cs, input bit wait_done);
        for (int i = 0; i < npix; i++) begin
            in_valid      = 1'b1;
            in_sof        = (i == 0);
            in_rgb        = 24'(i + 1);
            cfg_wr        = (i == cfg_at);
            cfg_threshold = 18'(ct);
            cfg_scale     = 4'(cs);
            tick(1);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            cfg_wr   = 1'b0;
            if (gaps && ($urandom_range(0, 1) == 1)) tick(1);
        end
        if (wait_done) begin
            for (int k = 0; k < 100; k++) begin
                if (n_done != b_done) break;
                tick(1);
            end
            check("done_timeout", int'(n_done != b_done), 1);
            tick(3);
        end
    endtask

    task automatic check_frame(input string p, input int thr, input int cc);
        int bad_xy, bad_c, nf, x, y, ec, last;
        nf = n_feat - b_feat;
        bad_xy = 0;
        bad_c = 0;
        for (int i = 0; i < N && i < nf; i++) begin
            x = i % H;
            y = i / H;
            ec = (x >= 2 && x <= H - 3 && y >= 2 && y <= V - 3 && 100 > thr)
                 ? 1 : 0;
            if (fx[(b_feat + i) % 1024] != x || fy[(b_feat + i) % 1024] != y)
                bad_xy++;
            if (fc[(b_feat + i) % 1024] != ec) bad_c++;
        end
        last = (b_feat + nf - 1) % 1024;
        check({p, "_nfeat"}, nf, N);
        check({p, "_xy_bad"}, bad_xy, 0);
        check({p, "_corner_bad"}, bad_c, 0);
        check({p, "_en_run"}, n_enrun - b_enrun, N);
        check({p, "_en_total"}, n_en - b_en, N + L);
        check({p, "_en_noacc"}, n_noacc - b_noacc, 0);
        check({p, "_ready0"}, n_rdy0 - b_rdy0, L);
        check({p, "_lat"}, f_at[b_feat % 1024] - en_at[(b_en + L) % 1024], 2);
        check({p, "_ndone"}, n_done - b_done, 1);
        check({p, "_done_dly"}, done_at - f_at[last], 1);
        check({p, "_count"}, int'(corner_count), cc);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        check("rst_ready", int'(in_ready), 1);
        check("rst_en", int'(det_clk_en), 0);
        check("rst_rgb", int'(det_rgb), 0);
        check("rst_thr", int'(det_threshold), 1000);
        check("rst_scl", int'(det_scale), 8);
        check("rst_cc", int'(corner_count), 0);
        check("rst_fv", int'(feat_valid), 0);

        snap();
        in_valid = 1'b1;
        in_sof = 1'b0;
        tick(3);
        in_valid = 1'b0;
        tick(1);
        check("idle_drop_en", n_en - b_en, 0);
        check("idle_drop_rdy", n_rdy0 - b_rdy0, 0);

        corner_thresh = 18'd50;
        snap();
        send_frame(N, 1'b0, -1, 0, 0, 1'b1);
        check_frame("f1", 50, 8);
        check("f1_first_x", fx[b_feat % 1024], 0);
        check("f1_8th_x", fx[(b_feat + 7) % 1024], 7);
        check("f1_8th_y", fy[(b_feat + 7) % 1024], 0);
        check("f1_last_y", fy[(b_feat + N - 1) % 1024], 5);

        corner_thresh = 18'd100;
        snap();
        send_frame(N, 1'b0, -1, 0, 0, 1'b1);
        check_frame("f2", 100, 0);

        corner_thresh = 18'd50;
        snap();
        send_frame(N, 1'b1, -1, 0, 0, 1'b1);
        check_frame("gap", 50, 8);

        corner_thresh = 18'd100;
        snap();
        send_frame(N, 1'b0, 10, 500, 3, 1'b1);
        check("cfg_mid_thr", int'(det_threshold), 1000);
        check("cfg_mid_scl", int'(det_scale), 8);
        check("cfg_mid_cc", int'(corner_count), 0);
        snap();
        send_frame(N, 1'b0, -1, 0, 0, 1'b1);
        check("cfg_next_thr", int'(det_threshold), 500);
        check("cfg_next_scl", int'(det_scale), 3);
        snap();
        send_frame(N, 1'b0, 0, 700, 5, 1'b1);
        check("cfg_sof_thr", int'(det_threshold), 700);
        check("cfg_sof_scl", int'(det_scale), 5);

        corner_thresh = 18'd50;
        snap();
        send_frame(20, 1'b0, -1, 0, 0, 1'b0);
        snap();
        send_frame(N, 1'b0, -1, 0, 0, 1'b1);
        check("rs_err", n_err - b_err, 1);
        check_frame("rs", 50, 8);

        snap();
        send_frame(N, 1'b0, -1, 0, 0, 1'b0);
        tick(5);
        check("pre_rst_flush", int'(in_ready), 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mr_ready", int'(in_ready), 1);
        check("mr_thr", int'(det_threshold), 1000);
        check("mr_scl", int'(det_scale), 8);
        check("mr_cc", int'(corner_count), 0);
        check("mr_fv", int'(feat_valid), 0);
        snap();
        in_valid = 1'b1;
        in_sof = 1'b0;
        tick(40);
        in_valid = 1'b0;
        tick(1);
        check("mr_drop_en", n_en - b_en, 0);
        check("mr_no_done", n_done - b_done, 0);
        check("mr_no_feat", n_feat - b_feat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
